// File: rtl/ewb_multi.sv
// Multi-entry eviction write buffer: queues dirty victim lines, merges repeats,
// serves miss lookups from buffered lines and drains to pmem in FIFO order.
module ewb_multi #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned LINE_W   = 256,
  parameter int unsigned TAG_W    = 27,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       evict_valid,
  output logic                       evict_ready,
  input  logic [TAG_W-1:0]           evict_addr,
  input  logic [LINE_W-1:0]          evict_data,
  input  logic [TAG_W-1:0]           lkup_addr,
  output logic                       lkup_hit,
  output logic [LINE_W-1:0]          lkup_data,
  input  logic                       mem_busy,
  output logic                       pmem_write,
  output logic [31:0]                pmem_address,
  output logic [LINE_W-1:0]          pmem_wdata,
  input  logic                       pmem_resp,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned WC_W  = $clog2(WAIT_CYC + 1);
  localparam int unsigned OFF_W = 32 - TAG_W;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE} state_t;

  state_t              state_q, state_d;
  logic [WC_W-1:0]     wait_q, wait_d;
  logic                pmem_write_q, pmem_write_d;
  logic [DEPTH-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_q  [DEPTH];
  logic [LINE_W-1:0]   data_q [DEPTH];
  logic [PTR_W-1:0]    head_q, tail_q;
  logic [CNT_W-1:0]    count_q, count_d;

  logic                push, pop, append, idle_cyc;
  logic                merge_hit;
  logic [PTR_W-1:0]    merge_idx;
  logic [PTR_W-1:0]    lk_idx;

  assign idle_cyc = !evict_valid && !mem_busy;
  assign push     = evict_valid && evict_ready;
  assign pop      = (state_q == S_WRITE) && pmem_resp;
  assign append   = push && !merge_hit;
  assign count_d  = count_q + CNT_W'(append) - CNT_W'(pop);

  // Merge target: any valid copy except the head while it is on the bus.
  always_comb begin
    merge_hit = 1'b0;
    merge_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (tag_q[i] == evict_addr) &&
          !((state_q == S_WRITE) && (PTR_W'(i) == head_q))) begin
        merge_hit = 1'b1;
        merge_idx = PTR_W'(i);
      end
    end
  end

  // Walk oldest to youngest so the newest matching copy wins.
  always_comb begin
    lkup_hit  = 1'b0;
    lkup_data = '0;
    lk_idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      lk_idx = head_q + PTR_W'(k);
      if (valid_q[lk_idx] && (tag_q[lk_idx] == lkup_addr)) begin
        lkup_hit  = 1'b1;
        lkup_data = data_q[lk_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (count_q != '0) state_d = S_WAIT;
      S_WAIT: begin
        if (count_q == '0)
          state_d = S_IDLE;
        else if (idle_cyc && (wait_q == WC_W'(WAIT_CYC - 1)))
          state_d = S_WRITE;
      end
      S_WRITE: if (pop) state_d = (count_d != '0) ? S_WAIT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Wait counter restarts on any push or busy cycle; write drops with the response.
  always_comb begin
    wait_d       = '0;
    pmem_write_d = 1'b0;
    if ((state_q == S_WAIT) && idle_cyc && (wait_q != WC_W'(WAIT_CYC - 1)))
      wait_d = wait_q + WC_W'(1);
    if ((state_q == S_WRITE) && !pmem_resp)
      pmem_write_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_q       <= '0;
      pmem_write_q <= 1'b0;
      valid_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
    end else begin
      wait_q       <= wait_d;
      pmem_write_q <= pmem_write_d;
      count_q      <= count_d;
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      if (append) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_W'(1);
      end
    end
  end

  // Line storage carries no reset; valid bits qualify every read.
  always_ff @(posedge clk) begin
    if (push) begin
      if (merge_hit) begin
        data_q[merge_idx] <= evict_data;
      end else begin
        tag_q[tail_q]  <= evict_addr;
        data_q[tail_q] <= evict_data;
      end
    end
  end

  assign evict_ready  = (count_q != CNT_W'(DEPTH));
  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign pmem_write   = pmem_write_q;
  assign pmem_address = {tag_q[head_q], OFF_W'(0)};
  assign pmem_wdata   = data_q[head_q];

endmodule

// File: tb/tb_ewb_multi.sv
// Directed bench for ewb_multi: vector table for fill/full/lookup plus
// hand sequences for drain latency, merging, head re-eviction and reset.
module tb_ewb_multi;
  logic         clk = 1'b0;
  logic         rst;
  logic         evict_valid;
  logic         evict_ready;
  logic [26:0]  evict_addr;
  logic [255:0] evict_data;
  logic [26:0]  lkup_addr;
  logic         lkup_hit;
  logic [255:0] lkup_data;
  logic         mem_busy;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;
  logic [2:0]   count;
  logic         empty;

  int checks   = 0;
  int failures = 0;

  ewb_multi dut (
    .clk(clk), .rst(rst),
    .evict_valid(evict_valid), .evict_ready(evict_ready),
    .evict_addr(evict_addr), .evict_data(evict_data),
    .lkup_addr(lkup_addr), .lkup_hit(lkup_hit), .lkup_data(lkup_data),
    .mem_busy(mem_busy), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ev;
    logic [26:0] addr;
    logic [7:0]  db;
    logic        busy;
    logic        resp;
    logic [26:0] lk;
    int          cnt;
    logic        rdy;
    logic        pw;
    logic        hit;
    logic [7:0]  lkb;
  } vec_t;

  vec_t tbl [6];

  function automatic logic [255:0] fill(input logic [7:0] b);
    return {32{b}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_pw();
    int n = 0;
    while (!pmem_write && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic push(input logic [26:0] a, input logic [7:0] db);
    evict_valid = 1'b1;
    evict_addr  = a;
    evict_data  = fill(db);
    tick();
    evict_valid = 1'b0;
  endtask

  task automatic drain_one(input string name, input logic [31:0] addr, input logic [7:0] db);
    wait_pw();
    chk({name, "_start"}, 256'(pmem_write), 256'(1));
    chk({name, "_addr"}, 256'(pmem_address), 256'(addr));
    chk({name, "_data"}, pmem_wdata, fill(db));
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    chk({name, "_wr_drop"}, 256'(pmem_write), 256'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // fill to full under mem_busy, reject overflow, ignore stray resp
    tbl[0] = '{1'b1, 27'h1, 8'h11, 1'b1, 1'b0, 27'h1, 1, 1'b1, 1'b0, 1'b1, 8'h11};
    tbl[1] = '{1'b1, 27'h2, 8'h22, 1'b1, 1'b0, 27'h1, 2, 1'b1, 1'b0, 1'b1, 8'h11};
    tbl[2] = '{1'b1, 27'h3, 8'h33, 1'b1, 1'b0, 27'h2, 3, 1'b1, 1'b0, 1'b1, 8'h22};
    tbl[3] = '{1'b1, 27'h4, 8'h44, 1'b1, 1'b0, 27'h4, 4, 1'b0, 1'b0, 1'b1, 8'h44};
    tbl[4] = '{1'b1, 27'h5, 8'h55, 1'b1, 1'b0, 27'h5, 4, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[5] = '{1'b0, 27'h0, 8'h00, 1'b1, 1'b1, 27'h3, 4, 1'b0, 1'b0, 1'b1, 8'h33};

    rst = 1'b0; evict_valid = 1'b0; evict_addr = '0; evict_data = '0;
    lkup_addr = '0; mem_busy = 1'b0; pmem_resp = 1'b0;
    tick(); tick();
    rst = 1'b1;
    chk("rst_pw", 256'(pmem_write), 256'(0));
    chk("rst_ready", 256'(evict_ready), 256'(1));
    chk("rst_hit", 256'(lkup_hit), 256'(0));
    chk("rst_empty", 256'(empty), 256'(1));
    chk("rst_count", 256'(count), 256'(0));

    // Test 1: single push, drain latency and response handling
    push(27'h1, 8'hAA);
    chk("t1_count", 256'(count), 256'(1));
    for (int n = 1; n <= 4; n++) begin
      tick();
      chk($sformatf("t1_pw_cyc%0d", n), 256'(pmem_write), 256'(n == 4));
    end
    chk("t1_addr", 256'(pmem_address), 256'(32'h20));
    chk("t1_data", pmem_wdata, fill(8'hAA));
    for (int n = 0; n < 2; n++) begin
      tick();
      chk($sformatf("t1_hold_pw%0d", n), 256'(pmem_write), 256'(1));
      chk($sformatf("t1_hold_addr%0d", n), 256'(pmem_address), 256'(32'h20));
    end
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    chk("t1_pw_drop", 256'(pmem_write), 256'(0));
    chk("t1_count_end", 256'(count), 256'(0));
    chk("t1_empty_end", 256'(empty), 256'(1));
    tick(); tick(); tick(); tick();
    chk("t1_idle_pw", 256'(pmem_write), 256'(0));

    // Test 2: vector table
    for (int i = 0; i < 6; i++) begin
      evict_valid = tbl[i].ev;
      evict_addr  = tbl[i].addr;
      evict_data  = fill(tbl[i].db);
      mem_busy    = tbl[i].busy;
      pmem_resp   = tbl[i].resp;
      lkup_addr   = tbl[i].lk;
      tick();
      chk($sformatf("t2_count%0d", i), 256'(count), 256'(tbl[i].cnt));
      chk($sformatf("t2_ready%0d", i), 256'(evict_ready), 256'(tbl[i].rdy));
      chk($sformatf("t2_pw%0d", i), 256'(pmem_write), 256'(tbl[i].pw));
      chk($sformatf("t2_hit%0d", i), 256'(lkup_hit), 256'(tbl[i].hit));
      chk($sformatf("t2_lkdata%0d", i), lkup_data, fill(tbl[i].lkb));
    end
    evict_valid = 1'b0; pmem_resp = 1'b0; mem_busy = 1'b0;
    drain_one("t2_w0", 32'h20, 8'h11);
    drain_one("t2_w1", 32'h40, 8'h22);
    drain_one("t2_w2", 32'h60, 8'h33);
    drain_one("t2_w3", 32'h80, 8'h44);
    chk("t2_empty", 256'(empty), 256'(1));

    // Test 3: merge of repeated evictions, no same-cycle bypass
    evict_valid = 1'b1; evict_addr = 27'h7; evict_data = fill(8'h71); lkup_addr = 27'h7;
    #1;
    chk("t3_no_bypass", 256'(lkup_hit), 256'(0));
    tick();
    evict_valid = 1'b0;
    push(27'h7, 8'h72);
    chk("t3_count", 256'(count), 256'(1));
    chk("t3_hit", 256'(lkup_hit), 256'(1));
    chk("t3_lkdata", lkup_data, fill(8'h72));
    drain_one("t3_w", 32'hE0, 8'h72);
    chk("t3_count_end", 256'(count), 256'(0));

    // Test 4: re-eviction of the head while it is being written
    push(27'h9, 8'h90);
    wait_pw();
    chk("t4_pw", 256'(pmem_write), 256'(1));
    push(27'h9, 8'h93);
    lkup_addr = 27'h9;
    #1;
    chk("t4_count", 256'(count), 256'(2));
    chk("t4_hit", 256'(lkup_hit), 256'(1));
    chk("t4_lkdata", lkup_data, fill(8'h93));
    chk("t4_addr_hold", 256'(pmem_address), 256'(32'h120));
    chk("t4_data_hold", pmem_wdata, fill(8'h90));
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    chk("t4_count_mid", 256'(count), 256'(1));
    drain_one("t4_w1", 32'h120, 8'h93);
    chk("t4_count_end", 256'(count), 256'(0));

    // Test 5: toggling evict_valid keeps the drain from starting
    push(27'hB, 8'hB0);
    for (int k = 0; k < 12; k++) begin
      evict_valid = k[0];
      evict_addr  = 27'hB;
      evict_data  = fill(8'hB0 + 8'(k));
      tick();
      chk($sformatf("t5_pw_k%0d", k), 256'(pmem_write), 256'(0));
    end
    evict_valid = 1'b0;
    chk("t5_count", 256'(count), 256'(1));
    for (int n = 1; n <= 3; n++) begin
      tick();
      chk($sformatf("t5_lat%0d", n), 256'(pmem_write), 256'(n == 3));
    end
    drain_one("t5_w", 32'h160, 8'hBB);

    // Test 6: reset in the middle of a write
    mem_busy = 1'b1;
    push(27'hC, 8'hC0);
    push(27'hD, 8'hD0);
    push(27'hE, 8'hE0);
    mem_busy = 1'b0;
    wait_pw();
    chk("t6_pw", 256'(pmem_write), 256'(1));
    chk("t6_count", 256'(count), 256'(3));
    rst = 1'b0;
    tick();
    chk("t6_pw_rst", 256'(pmem_write), 256'(0));
    chk("t6_count_rst", 256'(count), 256'(0));
    chk("t6_empty_rst", 256'(empty), 256'(1));
    chk("t6_ready_rst", 256'(evict_ready), 256'(1));
    for (int t = 12; t <= 14; t++) begin
      lkup_addr = 27'(t);
      #1;
      chk($sformatf("t6_hit_%0h", t), 256'(lkup_hit), 256'(0));
    end
    rst = 1'b1;
    tick(); tick(); tick(); tick();
    chk("t6_pw_after", 256'(pmem_write), 256'(0));
    chk("t6_count_after", 256'(count), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
